// File: rtl/flash_byte_reader.sv
// Byte-granular reader for the flash Avalon-MM port: fetches the 32-bit word that holds
// the requested byte, keeps that word in a one-entry cache and pulses finish_read when done.
module flash_byte_reader #(
    parameter int ADDR_W   = 21,
    parameter int TIMEOUT  = 255,
    parameter int CACHE_EN = 1
) (
    input  logic              clk,
    input  logic              reset_all,
    input  logic              read_start,
    input  logic [ADDR_W-1:0] addr_in,
    output logic              finish_read,
    output logic [7:0]        data_out,
    output logic              busy,
    output logic              timeout_err,
    output logic              flash_mem_read,
    output logic [ADDR_W-3:0] flash_mem_address,
    output logic [3:0]        flash_mem_byteenable,
    input  logic              flash_mem_waitrequest,
    input  logic [31:0]       flash_mem_readdata,
    input  logic              flash_mem_readdatavalid
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int TAG_W = ADDR_W - 2;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CHECK     = 3'd1,
        S_BUS_REQ   = 3'd2,
        S_WAIT_DATA = 3'd3,
        S_DONE      = 3'd4,
        S_RELEASE   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [31:0]       cache_word_q, cache_word_d;
    logic [TAG_W-1:0]  cache_tag_q, cache_tag_d;
    logic              cache_vld_q, cache_vld_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        data_q, data_d;
    logic              finish_q, finish_d;
    logic              read_q, read_d;
    logic              busy_q, busy_d;
    logic              terr_q, terr_d;
    logic              cache_hit_s;

    function automatic logic [7:0] select_byte(input logic [31:0] word, input logic [1:0] sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign cache_hit_s = (CACHE_EN != 0) && cache_vld_q &&
                         (req_addr_q[ADDR_W-1:2] == cache_tag_q);

    // Next-state, cache update and registered-output decode.
    always_comb begin
        state_d      = state_q;
        req_addr_d   = req_addr_q;
        cache_word_d = cache_word_q;
        cache_tag_d  = cache_tag_q;
        cache_vld_d  = cache_vld_q;
        cnt_d        = cnt_q;
        data_d       = data_q;
        terr_d       = terr_q;
        case (state_q)
            S_IDLE: begin
                if (read_start) begin
                    req_addr_d = addr_in;
                    state_d    = S_CHECK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CHECK: begin
                if (cache_hit_s) begin
                    data_d  = select_byte(cache_word_q, req_addr_q[1:0]);
                    state_d = S_DONE;
                end else begin
                    state_d = S_BUS_REQ;
                end
            end
            S_BUS_REQ: begin
                if (!flash_mem_waitrequest) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_DATA;
                end else begin
                    state_d = S_BUS_REQ;
                end
            end
            S_WAIT_DATA: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (flash_mem_readdatavalid) begin
                    cache_word_d = flash_mem_readdata;
                    cache_tag_d  = req_addr_q[ADDR_W-1:2];
                    cache_vld_d  = 1'b1;
                    data_d       = select_byte(flash_mem_readdata, req_addr_q[1:0]);
                    state_d      = S_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Abandoned read: report a zero byte and drop the cached word.
                    terr_d      = 1'b1;
                    cache_vld_d = 1'b0;
                    data_d      = 8'h00;
                    state_d     = S_DONE;
                end else begin
                    state_d = S_WAIT_DATA;
                end
            end
            S_DONE: begin
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (!read_start) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RELEASE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        finish_d = (state_d == S_DONE);
        read_d   = (state_d == S_BUS_REQ);
        busy_d   = (state_d != S_IDLE);
    end

    // State, cache and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset_all) begin
            state_q      <= S_IDLE;
            req_addr_q   <= '0;
            cache_word_q <= 32'h0000_0000;
            cache_tag_q  <= '0;
            cache_vld_q  <= 1'b0;
            cnt_q        <= '0;
            data_q       <= 8'h00;
            finish_q     <= 1'b0;
            read_q       <= 1'b0;
            busy_q       <= 1'b0;
            terr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_addr_q   <= req_addr_d;
            cache_word_q <= cache_word_d;
            cache_tag_q  <= cache_tag_d;
            cache_vld_q  <= cache_vld_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            finish_q     <= finish_d;
            read_q       <= read_d;
            busy_q       <= busy_d;
            terr_q       <= terr_d;
        end
    end

    assign finish_read          = finish_q;
    assign data_out             = data_q;
    assign busy                 = busy_q;
    assign timeout_err          = terr_q;
    assign flash_mem_read       = read_q;
    assign flash_mem_address    = req_addr_q[ADDR_W-1:2];
    assign flash_mem_byteenable = 4'hF;

endmodule

// File: tb/tb_flash_byte_reader.sv
// Directed bench: instance A (cache on, TIMEOUT=8) and instance B (cache off) share stimulus;
// sel_tb chooses which one receives read_start and is observed.
module tb_flash_byte_reader;
    logic        clk = 1'b0;
    logic        reset_all;
    logic        read_start;
    logic [20:0] addr_in;
    logic        waitreq;
    logic [31:0] readdata;
    logic        rdv;
    logic        sel_tb;

    logic        a_fin, b_fin, a_busy, b_busy, a_terr, b_terr, a_rd, b_rd;
    logic [7:0]  a_dout, b_dout;
    logic [18:0] a_addr, b_addr;
    logic [3:0]  a_be, b_be;

    logic        o_fin, o_busy, o_terr, o_rd;
    logic [7:0]  o_dout;
    logic [18:0] o_addr;
    logic [3:0]  o_be;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    flash_byte_reader #(.ADDR_W(21), .TIMEOUT(8), .CACHE_EN(1)) dut_a (
        .clk(clk), .reset_all(reset_all), .read_start(read_start & ~sel_tb), .addr_in(addr_in),
        .finish_read(a_fin), .data_out(a_dout), .busy(a_busy), .timeout_err(a_terr),
        .flash_mem_read(a_rd), .flash_mem_address(a_addr), .flash_mem_byteenable(a_be),
        .flash_mem_waitrequest(waitreq), .flash_mem_readdata(readdata),
        .flash_mem_readdatavalid(rdv));

    flash_byte_reader #(.ADDR_W(21), .TIMEOUT(8), .CACHE_EN(0)) dut_b (
        .clk(clk), .reset_all(reset_all), .read_start(read_start & sel_tb), .addr_in(addr_in),
        .finish_read(b_fin), .data_out(b_dout), .busy(b_busy), .timeout_err(b_terr),
        .flash_mem_read(b_rd), .flash_mem_address(b_addr), .flash_mem_byteenable(b_be),
        .flash_mem_waitrequest(waitreq), .flash_mem_readdata(readdata),
        .flash_mem_readdatavalid(rdv));

    assign o_fin  = sel_tb ? b_fin  : a_fin;
    assign o_busy = sel_tb ? b_busy : a_busy;
    assign o_terr = sel_tb ? b_terr : a_terr;
    assign o_rd   = sel_tb ? b_rd   : a_rd;
    assign o_dout = sel_tb ? b_dout : a_dout;
    assign o_addr = sel_tb ? b_addr : a_addr;
    assign o_be   = sel_tb ? b_be   : a_be;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One request: the bench acts as the flash slave with the given stall count and
    // readdatavalid latency (cycles after the accepting edge).
    task automatic do_read(input string tag, input logic [20:0] a, input int stalls, input int lat,
                           input logic [31:0] rdata, input bit give_rdv, input int exp_xfers,
                           input logic [18:0] exp_waddr, input logic [7:0] exp_byte,
                           input int exp_lat);
        int n, acc, stall_cnt, xfers, fin_at;
        logic [18:0] waddr_seen;
        logic [7:0]  dout_seen;
        @(negedge clk);
        read_start = 1'b1;
        addr_in    = a;
        n = 0; acc = -1; stall_cnt = 0; xfers = 0; fin_at = -1;
        waddr_seen = 19'h0; dout_seen = 8'h00;
        while (fin_at < 0 && n < 200) begin
            @(negedge clk);
            n++;
            addr_in  = ~a;
            rdv      = 1'b0;
            readdata = 32'h0;
            if (acc >= 0 && give_rdv && n == acc + lat) begin
                rdv      = 1'b1;
                readdata = rdata;
            end
            waitreq = 1'b0;
            if (o_rd) begin
                waddr_seen = o_addr;
                if (stall_cnt < stalls) begin
                    waitreq = 1'b1;
                    stall_cnt++;
                end else begin
                    xfers++;
                    acc = n;
                end
            end
            if (o_fin) begin
                fin_at    = n;
                dout_seen = o_dout;
            end
        end
        rdv     = 1'b0;
        waitreq = 1'b0;
        check_eq({tag, "_lat"}, fin_at, exp_lat);
        check_eq({tag, "_data"}, {24'h0, dout_seen}, {24'h0, exp_byte});
        check_eq({tag, "_xfers"}, xfers, exp_xfers);
        if (exp_xfers > 0) check_eq({tag, "_waddr"}, {13'h0, waddr_seen}, {13'h0, exp_waddr});
        @(negedge clk);
        check_eq({tag, "_pulse_end"}, {31'h0, o_fin}, 32'h0);
        check_eq({tag, "_release_busy"}, {31'h0, o_busy}, 32'h1);
        read_start = 1'b0;
        @(negedge clk);
        check_eq({tag, "_idle"}, {31'h0, o_busy}, 32'h0);
    endtask

    initial begin
        int fin_seen;
        reset_all = 1'b1; read_start = 1'b0; addr_in = 21'h0;
        waitreq = 1'b0; readdata = 32'h0; rdv = 1'b0; sel_tb = 1'b0;
        repeat (2) @(negedge clk);
        reset_all = 1'b0;
        @(negedge clk);
        check_eq("rst_finish", {31'h0, o_fin}, 32'h0);
        check_eq("rst_data", {24'h0, o_dout}, 32'h0);
        check_eq("rst_read", {31'h0, o_rd}, 32'h0);
        check_eq("rst_addr", {13'h0, o_addr}, 32'h0);
        check_eq("rst_busy", {31'h0, o_busy}, 32'h0);
        check_eq("rst_terr", {31'h0, o_terr}, 32'h0);
        check_eq("byteenable", {28'h0, o_be}, 32'hF);

        do_read("miss_stall", 21'h000004, 3, 2, 32'hDDCCBBAA, 1'b1, 1, 19'h1, 8'hAA, 8);
        do_read("hit_b1", 21'h000005, 0, 1, 32'h0, 1'b1, 0, 19'h0, 8'hBB, 2);
        do_read("hit_b3", 21'h000007, 0, 1, 32'h0, 1'b1, 0, 19'h0, 8'hDD, 2);
        do_read("top_addr", 21'h1FFFFF, 0, 1, 32'h12345678, 1'b1, 1, 19'h7FFFF, 8'h12, 4);
        do_read("timeout", 21'h000100, 0, 1, 32'hFFFFFFFF, 1'b0, 1, 19'h40, 8'h00, 11);
        check_eq("terr_set", {31'h0, o_terr}, 32'h1);
        do_read("after_to", 21'h000101, 0, 1, 32'hA1B2C3D4, 1'b1, 1, 19'h40, 8'hC3, 4);
        check_eq("terr_sticky", {31'h0, o_terr}, 32'h1);

        // Reset while in WAIT_DATA, then a stray readdatavalid.
        @(negedge clk);
        read_start = 1'b1;
        addr_in    = 21'h000200;
        repeat (3) @(negedge clk);
        check_eq("mid_busy", {31'h0, o_busy}, 32'h1);
        check_eq("mid_read_low", {31'h0, o_rd}, 32'h0);
        reset_all  = 1'b1;
        read_start = 1'b0;
        @(negedge clk);
        reset_all = 1'b0;
        rdv       = 1'b1;
        readdata  = 32'hCAFEBABE;
        fin_seen  = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rdv = 1'b0;
            if (o_fin) fin_seen++;
        end
        check_eq("mid_no_finish", fin_seen, 0);
        check_eq("mid_idle", {31'h0, o_busy}, 32'h0);
        check_eq("mid_terr_clr", {31'h0, o_terr}, 32'h0);
        do_read("mid_remiss", 21'h000202, 0, 1, 32'h55667788, 1'b1, 1, 19'h80, 8'h66, 4);
        do_read("old_word_miss", 21'h000103, 0, 1, 32'h0BADF00D, 1'b1, 1, 19'h40, 8'h0B, 4);

        sel_tb = 1'b1;
        do_read("nc_first", 21'h000004, 0, 1, 32'hDDCCBBAA, 1'b1, 1, 19'h1, 8'hAA, 4);
        do_read("nc_second", 21'h000005, 0, 1, 32'hDDCCBBAA, 1'b1, 1, 19'h1, 8'hBB, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
